// File: rtl/ifm_skew_feeder_pkg.sv
// Shared constants, FSM state type and address-wrap helper for the IFM skew feeder.
// Optional build macro used by the top: IFM_ZERO_PAD_EN.
package ifm_skew_feeder_pkg;

   localparam int SYS_HEIGHT              = 9;
   localparam int IFM_PER_BYTE_BIT        = 8;
   localparam int IFM_SRAM_ADDR_SHORT_BIT = 7;
   localparam int IFM_SRAM_DEPTH_SHORT    = 96;

   localparam int BYTE_W = IFM_PER_BYTE_BIT;
   localparam int ADDR_W = IFM_SRAM_ADDR_SHORT_BIT;
   localparam int DEPTH  = IFM_SRAM_DEPTH_SHORT;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } ifm_feed_state_t;

   // base+k never exceeds 2*DEPTH-2, so a single conditional subtract wraps it.
   function automatic logic [ADDR_W:0] wrap_addr(input logic [ADDR_W:0] sum);
      return (sum >= (ADDR_W+1)'(DEPTH)) ? sum - (ADDR_W+1)'(DEPTH) : sum;
   endfunction

endpackage

// File: rtl/ifm_skew_feeder_skew_line.sv
// One row's {valid, byte} delay line of DELAY stages (DELAY >= 1).
// Data only advances behind a valid tag, so an idle stage keeps its last byte.
module ifm_skew_line
   import ifm_skew_feeder_pkg::*;
#(
   parameter int DELAY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [BYTE_W-1:0] i_data,
   output logic              o_valid,
   output logic [BYTE_W-1:0] o_data
);

   logic [DELAY-1:0]  r_valid;
   logic [BYTE_W-1:0] r_data [DELAY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < DELAY; i++) r_data[i] <= '0;
      end else begin
         r_valid[0] <= i_valid;
         if (i_valid) r_data[0] <= i_data;
         for (int i = 1; i < DELAY; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) r_data[i] <= r_data[i-1];
         end
      end
   end

   assign o_valid = r_valid[DELAY-1];
   assign o_data  = r_data[DELAY-1];

endmodule

// File: rtl/ifm_skew_feeder.sv
// Streams len IFM SRAM words from base_addr into the array rows with a diagonal skew.
// Build macro IFM_ZERO_PAD_EN: force out_data lanes to zero while their out_valid is low.
module ifm_skew_feeder
   import ifm_skew_feeder_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_W-1:0]            base_addr,
   input  logic [ADDR_W-1:0]            len,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_W-1:0]            sram_A,
   output logic                         sram_CS,
   output logic                         sram_OE,
   output logic [SYS_HEIGHT-1:0]        sram_WEB,
   input  logic [SYS_HEIGHT*BYTE_W-1:0] sram_DO,
   output logic [SYS_HEIGHT*BYTE_W-1:0] out_data,
   output logic [SYS_HEIGHT-1:0]        out_valid,
   output logic [1:0]                   o_dbg_state
);

   ifm_feed_state_t             r_state;
   logic [ADDR_W-1:0]           r_base;
   logic [ADDR_W:0]             r_len;
   logic [ADDR_W:0]             r_k;
   logic [ADDR_W:0]             r_drain;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_cs;
   logic [ADDR_W-1:0]           r_a;
   logic                        r_cs_d;
   logic                        r_cap_valid;
   logic [SYS_HEIGHT*BYTE_W-1:0] r_cap_data;

   logic [ADDR_W:0]   w_len_ext;
   logic [ADDR_W:0]   w_len_clamp;
   logic [ADDR_W:0]   w_k_next;
   logic [ADDR_W:0]   w_a_next;
   logic [SYS_HEIGHT-1:0] w_row_valid;
   logic [BYTE_W-1:0]     w_row_data [SYS_HEIGHT];

   assign w_len_ext   = {1'b0, len};
   assign w_len_clamp = (w_len_ext > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : w_len_ext;
   assign w_k_next    = r_k + (ADDR_W+1)'(1);
   assign w_a_next    = wrap_addr({1'b0, r_base} + w_k_next);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_len   <= '0;
         r_k     <= '0;
         r_drain <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cs    <= 1'b0;
         r_a     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_base  <= base_addr;
                  r_len   <= w_len_clamp;
                  r_k     <= '0;
                  r_drain <= '0;
                  r_busy  <= 1'b1;
                  if (w_len_clamp == '0) begin
                     r_state <= FLUSH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ISSUE;
                     r_cs    <= 1'b1;
                     r_a     <= base_addr;
                  end
               end
            end
            ISSUE: begin
               if (r_k == r_len - (ADDR_W+1)'(1)) begin
                  r_state <= DRAIN;
                  r_cs    <= 1'b0;
               end else begin
                  r_k <= w_k_next;
                  r_a <= w_a_next[ADDR_W-1:0];
               end
            end
            DRAIN: begin
               // The last word reaches the bottom row SYS_HEIGHT+1 cycles after its read;
               // done is raised one cycle early so it lands with that row's valid.
               if (r_done) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_drain == (ADDR_W+1)'(SYS_HEIGHT-1)) r_done <= 1'b1;
                  r_drain <= r_drain + (ADDR_W+1)'(1);
               end
            end
            FLUSH: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cs_d      <= 1'b0;
         r_cap_valid <= 1'b0;
         r_cap_data  <= '0;
      end else begin
         r_cs_d      <= r_cs;
         r_cap_valid <= r_cs_d;
         if (r_cs_d) r_cap_data <= sram_DO;
      end
   end

   genvar g_r;
   generate
      for (g_r = 0; g_r < SYS_HEIGHT; g_r++) begin : g_row
         if (g_r == 0) begin : g_row0
            assign w_row_valid[0] = r_cap_valid;
            assign w_row_data[0]  = r_cap_data[BYTE_W-1:0];
         end else begin : g_rowd
            ifm_skew_line #(.DELAY(g_r)) u_line (
               .clk     (clk),
               .rst     (rst),
               .i_valid (r_cap_valid),
               .i_data  (r_cap_data[g_r*BYTE_W +: BYTE_W]),
               .o_valid (w_row_valid[g_r]),
               .o_data  (w_row_data[g_r])
            );
         end
`ifdef IFM_ZERO_PAD_EN
         assign out_data[g_r*BYTE_W +: BYTE_W] = w_row_valid[g_r] ? w_row_data[g_r] : '0;
`else
         assign out_data[g_r*BYTE_W +: BYTE_W] = w_row_data[g_r];
`endif
      end
   endgenerate

   assign out_valid   = w_row_valid;
   assign busy        = r_busy;
   assign done        = r_done;
   assign sram_A      = r_a;
   assign sram_CS     = r_cs;
   assign sram_OE     = r_busy;
   assign sram_WEB    = '1;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// Scoreboard bench for ifm_skew_feeder: tasks push expected {value, cycle} entries,
// a negedge monitor pops and compares whenever CS or a row valid is seen.
module tb_ifm_skew_feeder;
   import ifm_skew_feeder_pkg::*;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         start;
   logic [ADDR_W-1:0]            base_addr;
   logic [ADDR_W-1:0]            len;
   logic                         busy;
   logic                         done;
   logic [ADDR_W-1:0]            sram_A;
   logic                         sram_CS;
   logic                         sram_OE;
   logic [SYS_HEIGHT-1:0]        sram_WEB;
   logic [SYS_HEIGHT*BYTE_W-1:0] sram_DO;
   logic [SYS_HEIGHT*BYTE_W-1:0] out_data;
   logic [SYS_HEIGHT-1:0]        out_valid;
   logic [1:0]                   o_dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [SYS_HEIGHT*BYTE_W-1:0] mem [DEPTH];
   logic [39:0] exp_q [SYS_HEIGHT][$];
   logic [38:0] exp_a_q[$];
   logic [39:0] e_row;
   logic [38:0] e_a;

   ifm_skew_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .sram_A      (sram_A),
      .sram_CS     (sram_CS),
      .sram_OE     (sram_OE),
      .sram_WEB    (sram_WEB),
      .sram_DO     (sram_DO),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .o_dbg_state (o_dbg_state)
   );

   // clock / SRAM model
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (sram_CS) sram_DO <= mem[sram_A];

   // monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (sram_CS) begin
            checks++;
            if (exp_a_q.size() == 0) begin
               errors++;
               $display("FAIL addr_unexpected got A=%0d at cyc %0d required no CS", sram_A, cyc);
            end else begin
               e_a = exp_a_q.pop_front();
               if ({sram_A, 32'(cyc)} !== e_a) begin
                  errors++;
                  $display("FAIL addr got A=%0d@%0d required A=%0d@%0d", sram_A, cyc, e_a[38:32], e_a[31:0]);
               end
            end
         end
         for (int r = 0; r < SYS_HEIGHT; r++) begin
            if (out_valid[r]) begin
               checks++;
               if (exp_q[r].size() == 0) begin
                  errors++;
                  $display("FAIL row%0d_unexpected got %02h at cyc %0d required no valid", r, out_data[r*BYTE_W +: BYTE_W], cyc);
               end else begin
                  e_row = exp_q[r].pop_front();
                  if ({out_data[r*BYTE_W +: BYTE_W], 32'(cyc)} !== e_row) begin
                     errors++;
                     $display("FAIL row%0d got %02h@%0d required %02h@%0d", r, out_data[r*BYTE_W +: BYTE_W], cyc, e_row[39:32], e_row[31:0]);
                  end
               end
            end
`ifdef IFM_ZERO_PAD_EN
            else begin
               checks++;
               if (out_data[r*BYTE_W +: BYTE_W] !== '0) begin
                  errors++;
                  $display("FAIL zero_pad row%0d got %02h required 00", r, out_data[r*BYTE_W +: BYTE_W]);
               end
            end
`endif
         end
         checks++;
         if (sram_OE !== busy || sram_WEB !== '1) begin
            errors++;
            $display("FAIL ctl got OE=%b busy=%b WEB=%b required OE=busy WEB=all ones", sram_OE, busy, sram_WEB);
         end
         if (done) done_cnt++;
      end
   end

   // driver tasks
   task automatic push_exp(input int base, input int lc, input int p);
      int a;
      for (int i = 0; i < lc; i++) begin
         a = (base + i) % DEPTH;
         exp_a_q.push_back({7'(a), 32'(p + i)});
         for (int r = 0; r < SYS_HEIGHT; r++)
            exp_q[r].push_back({mem[a][r*BYTE_W +: BYTE_W], 32'(p + i + 2 + r)});
      end
   endtask

   task automatic check_queues_empty(input string name);
      int left;
      left = exp_a_q.size();
      for (int r = 0; r < SYS_HEIGHT; r++) left += exp_q[r].size();
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL %s_leftover got %0d pending entries required 0", name, left);
      end
   endtask

   // Starts a transfer at the next edge; restart_at>0 pulses start with another base mid-transfer.
   task automatic xfer(input int base, input int len_in, input int restart_at);
      int lc, lat, n;
      bit seen, busy_ok;
      lc  = (len_in > DEPTH) ? DEPTH : len_in;
      lat = (lc == 0) ? 1 : lc + SYS_HEIGHT + 1;
      push_exp(base, lc, cyc + 1);
      base_addr = 7'(base);
      len       = 7'(len_in);
      start     = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      n       = 1;
      seen    = 1'b0;
      busy_ok = 1'b1;
      while (n <= 300) begin
         if (!busy) busy_ok = 1'b0;
         if (n == restart_at) begin
            start     = 1'b1;
            base_addr = 7'((base + 37) % DEPTH);
         end else if (n == restart_at + 1) begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout base=%0d len=%0d got no done in 300 cycles required done at %0d", base, len_in, lat);
      end else if (n != lat) begin
         errors++;
         $display("FAIL done_latency base=%0d len=%0d got %0d required %0d", base, len_in, n, lat);
      end
      checks++;
      if (!busy_ok) begin
         errors++;
         $display("FAIL busy_hold base=%0d len=%0d got busy low before done required high", base, len_in);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || o_dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL post_done got busy=%b done=%b state=%0d required 0 0 0", busy, done, o_dbg_state);
      end
      check_queues_empty("xfer");
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sram_A !== '0 || sram_CS !== 1'b0 || sram_OE !== 1'b0 ||
          out_data !== '0 || out_valid !== '0 || sram_WEB !== '1 || o_dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL %s got busy=%b done=%b A=%0d CS=%b OE=%b valid=%b data=%h WEB=%b required zeros with WEB all ones",
                  name, busy, done, sram_A, sram_CS, sram_OE, out_valid, out_data, sram_WEB);
      end
   endtask

   initial begin
      int d0;
      for (int w = 0; w < DEPTH; w++)
         for (int r = 0; r < SYS_HEIGHT; r++)
            mem[w][r*BYTE_W +: BYTE_W] = 8'(16 * w + 16 + r);
      sram_DO   = '0;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      len       = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      rst = 1'b0;
      @(negedge clk);

      xfer(0, 1, 0);
      xfer(94, 4, 0);
      xfer(7, 0, 0);

      d0 = done_cnt;
      xfer(20, 5, 2);
      repeat (15) @(negedge clk);
      checks++;
      if (done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL restart_done_count got %0d required 1", done_cnt - d0);
      end
      check_queues_empty("restart");

      // reset during DRAIN after all three reads issued
      push_exp(5, 3, cyc + 1);
      base_addr = 7'd5;
      len       = 7'd3;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_all_zero("reset_in_drain");
      exp_a_q.delete();
      for (int r = 0; r < SYS_HEIGHT; r++) exp_q[r].delete();
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL reset_no_done got %0d done pulses required 0", done_cnt - d0);
      end
      xfer(30, 2, 0);

      xfer(10, 100, 0);
      xfer(95, 3, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifm_skew_feeder.md
Name: ifm_skew_feeder

Overview:
Read-side sequencer for the 96-word short IFM SRAM (9 bytes/word, one byte per systolic-array row). On `start` it streams `len` consecutive words from `base_addr` and presents them to the systolic array with a diagonal skew: row r is delayed r cycles. It pulses `done` when the last byte leaves row SYS_HEIGHT-1. It sits between the IFM SRAM wrapper and the systolic-array west-edge inputs.

Parameters:
SYS_HEIGHT, 9, number of array rows (bytes per SRAM word)
BYTE_W, 8, bits per IFM byte
ADDR_W, 7, SRAM address width
DEPTH, 96, SRAM words; address wrap modulus

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a transfer; sampled only in IDLE
base_addr  in  ADDR_W  first word address (0..DEPTH-1)
len  in  ADDR_W  number of words; 0 allowed, values >DEPTH clamp to DEPTH
busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
done  out  1  one-cycle completion pulse
sram_A  out  ADDR_W  SRAM address
sram_CS  out  1  SRAM chip select, high only on read-issue cycles
sram_OE  out  1  SRAM output enable, high while busy
sram_WEB  out  SYS_HEIGHT  byte write enables, active low, constant all-ones (read-only)
sram_DO  in  BYTE_W x SYS_HEIGHT  SRAM read data, valid the cycle after CS
out_data  out  BYTE_W x SYS_HEIGHT  skewed bytes to array rows
out_valid  out  SYS_HEIGHT  per-row valid

Behaviour:
- Reset: IDLE state; busy=0, done=0, sram_A=0, sram_CS=0, sram_OE=0, out_data=0, out_valid=0, all counters and delay lines 0. Reset mid-transfer aborts immediately with no done pulse. Output sram_WEB is all-ones in reset and in every later cycle.
- FSM states:
  - IDLE: on start=1, latch base_addr and clamped len; go to ISSUE, or to FLUSH if len=0.
  - ISSUE: each cycle, drive sram_CS=1 and sram_A=addr with word counter k. addr = base+k; if base+k >= DEPTH, addr = base+k-DEPTH (wraps 95->0). After the last word (k=len-1), go to DRAIN.
  - DRAIN: no reads. Wait until the last word has left row SYS_HEIGHT-1, then go to IDLE.
  - FLUSH: len=0 only. Assert done for exactly one cycle, then go to IDLE.
- Row pipeline timing:
  - Read issued in cycle t: sram_DO is valid in t+1 and registered on that edge.
  - Row 0 presents the byte in t+2 with out_valid[0]=1.
  - Row r presents it in t+2+r through an r-stage delay line.
  - out_valid[r] travels with the data in the same delay line.
- done and busy:
  - done=1 in the same cycle out_valid[SYS_HEIGHT-1] shows the final word.
  - The next cycle is IDLE with busy=0.
  - Latency from the start-sampling edge to done: len+SYS_HEIGHT+1 cycles (len>=1).
- Back-to-back: start is accepted the cycle after done. Start while busy is ignored, with no effect on the current transfer.
- Invalid lanes: out_data holds its last value (see feature).
- Widths: k and the address adder are ADDR_W+1 bits so no compare overflows.

Optional Feature:
Macro IFM_ZERO_PAD_EN.
- Defined: out_data[r] is forced to 0 whenever out_valid[r]=0, so the array sees zero padding at the diagonal edges.
- Undefined: out_data[r] keeps its last shifted value when invalid. Consumers must gate on out_valid.

Decomposition:
- Shared definitions in TPU_def.svh (existing constants):
  - SYS_HEIGHT, IFM_PER_BYTE_BIT, IFM_SRAM_ADDR_SHORT_BIT
  - new IFM_SRAM_DEPTH_SHORT = 96
  - state typedef ifm_feed_state_t {IDLE, ISSUE, DRAIN, FLUSH}
- Sub-module ifm_skew_line (parameter DELAY): per-row {valid, byte} shift register with async reset. Instantiated once per row in a generate loop, with DELAY=r.

Test Plan:
- base=0, len=1, SRAM word 0 = bytes 0x10..0x18 -> CS in one cycle at A=0. Row r shows 0x10+r at cycle start+2+r. done at start+SYS_HEIGHT+2, i.e. 11 cycles after the start edge.
- base=94, len=4 -> A sequence 94,95,0,1. Each row outputs the 4 words in order on consecutive cycles. busy stays high throughout.
- len=0 -> no CS pulse, no out_valid; done=1 in the cycle after start, then IDLE.
- start pulsed again mid-ISSUE with a different base -> ignored: address sequence unchanged, and exactly one done.
- rst asserted in DRAIN, after 3 words -> all outputs 0 in the same cycle, no done. A following start with len=2 completes normally.
- len=100 -> clamped to 96: addresses base..wrap, 96 CS cycles. done 96+10 cycles after start. With IFM_ZERO_PAD_EN, invalid lanes read 0x00.
